hilo_muldiv: RTL and testbench

//  HI/LO register pair with an iterative multiply/divide engine for the MIPS-style CPU core.

---
 rtl/hilo_muldiv.sv | 213 +++++++++++++++++++++
 tb/tb_hilo_muldiv.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv.sv
// HI/LO register pair with an iterative radix-2 multiplier and restoring divider.
// All state advances on the falling clock edge; reset is asynchronous and active-high.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for start; direct HI/LO writes and fast multiplies here
// RUN   | one shift-add / restoring-divide iteration per edge, WIDTH edges
// FIXUP | restore signs, commit result to HI/LO, pulse done
module hilo_muldiv #(
    parameter int WIDTH    = 32,
    parameter int FAST_MUL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mt_we,
    input  logic [1:0]       mt_sel,
    input  logic [WIDTH-1:0] mt_hi,
    input  logic [WIDTH-1:0] mt_lo,
    output logic [WIDTH-1:0] out_hi,
    output logic [WIDTH-1:0] out_lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   p;
    logic [2*WIDTH-1:0]   p_step;
    logic [WIDTH-1:0]     d_r;
    logic [WIDTH-1:0]     a_r;
    logic                 is_div;
    logic                 neg_q;
    logic                 neg_r;
    logic                 b_zero;

    logic                 accept;
    logic                 fast;
    logic                 launch;
    logic                 mt_wr;
    logic                 last_iter;

    logic                 is_signed;
    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;

    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_sub;

    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     res_hi;
    logic [WIDTH-1:0]     res_lo;

    logic [2*WIDTH-1:0]   fa;
    logic [2*WIDTH-1:0]   fb;
    logic [2*WIDTH-1:0]   fast_prod;

    assign accept    = (state == IDLE) && start;
    assign fast      = accept && (FAST_MUL != 0) && !op[1];
    assign launch    = accept && !fast;
    assign mt_wr     = (state == IDLE) && mt_we && !start;
    assign last_iter = (cnt == CW'(WIDTH - 1));

    // Signed ops iterate on magnitudes; the most-negative value maps to 2^(WIDTH-1) unsigned.
    assign is_signed = !op[0];
    assign a_neg     = is_signed && a[WIDTH-1];
    assign b_neg     = is_signed && b[WIDTH-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (launch) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_nxt = FIXUP;
                end
            end
            FIXUP: begin
                busy      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // p holds {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        mul_sum   = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, d_r} : '0);
        div_shift = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, d_r});
        div_sub   = div_shift[WIDTH-1:0] - d_r;
        p_step    = {mul_sum, p[WIDTH-1:1]};
        if (is_div) begin
            if (div_ge) begin
                p_step = {div_sub, p[WIDTH-2:0], 1'b1};
            end else begin
                p_step = {div_shift[WIDTH-1:0], p[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        prod_fix = neg_q ? -p : p;
        res_hi   = prod_fix[2*WIDTH-1:WIDTH];
        res_lo   = prod_fix[WIDTH-1:0];
        if (is_div) begin
            if (b_zero) begin
                res_hi = a_r;
                res_lo = '1;
            end else begin
                res_lo = neg_q ? -p[WIDTH-1:0] : p[WIDTH-1:0];
                res_hi = neg_r ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
            end
        end
    end

    always_comb begin
        fa        = op[0] ? {{WIDTH{1'b0}}, a} : {{WIDTH{a[WIDTH-1]}}, a};
        fb        = op[0] ? {{WIDTH{1'b0}}, b} : {{WIDTH{b[WIDTH-1]}}, b};
        fast_prod = fa * fb;
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            p      <= '0;
            d_r    <= '0;
            a_r    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
        end else if (launch) begin
            cnt    <= '0;
            p      <= op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
            d_r    <= op[1] ? b_mag : a_mag;
            a_r    <= a;
            is_div <= op[1];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            b_zero <= (b == '0);
        end else if (state == RUN) begin
            cnt <= cnt + CW'(1);
            p   <= p_step;
        end
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            out_hi   <= '0;
            out_lo   <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= (state == FIXUP) || fast;
            if (accept) begin
                div_zero <= 1'b0;
            end else if ((state == FIXUP) && is_div && b_zero) begin
                div_zero <= 1'b1;
            end
            if (state == FIXUP) begin
                out_hi <= res_hi;
                out_lo <= res_lo;
            end else if (fast) begin
                out_hi <= fast_prod[2*WIDTH-1:WIDTH];
                out_lo <= fast_prod[WIDTH-1:0];
            end else if (mt_wr) begin
                if (mt_sel[1]) begin
                    out_hi <= mt_hi;
                    out_lo <= mt_lo;
                end else if (mt_sel[0]) begin
                    out_hi <= mt_hi;
                end else begin
                    out_lo <= mt_lo;
                end
            end
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv: iterative instance plus a FAST_MUL instance on shared inputs.
// Inputs change and outputs are sampled 1 time unit after each falling (active) edge.
module tb_hilo_muldiv;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        mt_we;
    logic [1:0]  mt_sel;
    logic [31:0] mt_hi, mt_lo;

    logic [31:0] hi_s, lo_s, hi_f, lo_f;
    logic        busy_s, done_s, dz_s, busy_f, done_f, dz_f;

    int n_assert = 0;
    int n_fail   = 0;
    int saw_done;

    always #5 clk = ~clk;

    hilo_muldiv #(.WIDTH(32), .FAST_MUL(0)) dut_slow (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .mt_we(mt_we), .mt_sel(mt_sel), .mt_hi(mt_hi), .mt_lo(mt_lo),
        .out_hi(hi_s), .out_lo(lo_s), .busy(busy_s), .done(done_s), .div_zero(dz_s)
    );

    hilo_muldiv #(.WIDTH(32), .FAST_MUL(1)) dut_fast (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .mt_we(mt_we), .mt_sel(mt_sel), .mt_hi(mt_hi), .mt_lo(mt_lo),
        .out_hi(hi_f), .out_lo(lo_f), .busy(busy_f), .done(done_f), .div_zero(dz_f)
    );

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic mt_write(input logic [1:0] sel, input logic [31:0] h, input logic [31:0] l);
        mt_we = 1'b1; mt_sel = sel; mt_hi = h; mt_lo = l;
        tick();
        mt_we = 1'b0; mt_hi = 32'hBAD0BAD0; mt_lo = 32'hBAD1BAD1;
    endtask

    // Runs one iterative operation on dut_slow and checks the full E0..E34 timeline.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] hold_hi,
                         input logic [31:0] hold_lo, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input logic exp_dz,
                         input logic chk_fast, input logic pulse_mid);
        start = 1'b1; op = o; a = x; b = y;
        tick();
        start = 1'b0; op = ~o; a = $urandom; b = $urandom;
        chk({tag, " busy@E0"}, busy_s, 1'b1);
        chk({tag, " dz@E0"}, dz_s, 1'b0);
        chk({tag, " hold@E0"}, {hi_s, lo_s}, {hold_hi, hold_lo});
        if (chk_fast) begin
            chk({tag, " fast hilo@E0"}, {hi_f, lo_f}, {exp_hi, exp_lo});
            chk({tag, " fast done@E0"}, done_f, 1'b1);
            chk({tag, " fast busy@E0"}, busy_f, 1'b0);
        end
        tick();
        if (chk_fast) chk({tag, " fast done@E1"}, done_f, 1'b0);
        if (pulse_mid) begin
            repeat (8) tick();
            start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd5;
            mt_we = 1'b1; mt_sel = 2'b10; mt_hi = 32'hDEADBEEF; mt_lo = 32'hCAFEF00D;
            tick();
            start = 1'b0; mt_we = 1'b0;
            repeat (22) tick();
        end else begin
            repeat (31) tick();
        end
        chk({tag, " busy@E32"}, busy_s, 1'b1);
        chk({tag, " done@E32"}, done_s, 1'b0);
        chk({tag, " hold@E32"}, {hi_s, lo_s}, {hold_hi, hold_lo});
        if (chk_fast) chk({tag, " fast busy@E32"}, busy_f, 1'b0);
        tick();
        chk({tag, " done@E33"}, done_s, 1'b1);
        chk({tag, " busy@E33"}, busy_s, 1'b0);
        chk({tag, " hi"}, hi_s, exp_hi);
        chk({tag, " lo"}, lo_s, exp_lo);
        chk({tag, " div_zero"}, dz_s, exp_dz);
        tick();
        chk({tag, " done@E34"}, done_s, 1'b0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        mt_we = 1'b0; mt_sel = 2'b00; mt_hi = '0; mt_lo = '0;
        #12;
        chk("reset hilo", {hi_s, lo_s}, 64'h0);
        chk("reset busy", busy_s, 1'b0);
        chk("reset done", done_s, 1'b0);
        chk("reset dz", dz_s, 1'b0);
        chk("reset fast hilo", {hi_f, lo_f, dz_f}, 65'h0);
        reset = 1'b0;
        tick();

        mt_write(2'b10, 32'h11, 32'h22);
        chk("mt both", {hi_s, lo_s}, {32'h11, 32'h22});
        mt_write(2'b01, 32'h33, 32'h99);
        chk("mt hi only", {hi_s, lo_s}, {32'h33, 32'h22});
        mt_write(2'b00, 32'h77, 32'h44);
        chk("mt lo only", {hi_s, lo_s}, {32'h33, 32'h44});

        do_op("MULT -2*3", 2'b00, 32'hFFFFFFFE, 32'd3, 32'h33, 32'h44,
              32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 1'b0, 1'b0);
        do_op("MULTU max*max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFA,
              32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b1, 1'b0);
        do_op("DIV -7/2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFE, 32'h00000001,
              32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b0);
        do_op("DIV minneg/-1", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFD,
              32'h00000000, 32'h80000000, 1'b0, 1'b0, 1'b0);
        do_op("DIVU 7/0", 2'b11, 32'd7, 32'd0, 32'h00000000, 32'h80000000,
              32'd7, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
        chk("div_zero sticky", dz_s, 1'b1);
        do_op("MULTU 2*3", 2'b01, 32'd2, 32'd3, 32'd7, 32'hFFFFFFFF,
              32'd0, 32'd6, 1'b0, 1'b0, 1'b0);
        do_op("DIVU 100/7 midpulse", 2'b11, 32'd100, 32'd7, 32'd0, 32'd6,
              32'd2, 32'd14, 1'b0, 1'b0, 1'b1);

        mt_write(2'b10, 32'h55, 32'h66);
        start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
        tick();
        start = 1'b0;
        repeat (9) tick();
        chk("pre-reset busy", busy_s, 1'b1);
        reset = 1'b1;
        #1;
        chk("async reset hilo", {hi_s, lo_s}, 64'h0);
        chk("async reset busy", busy_s, 1'b0);
        tick();
        reset = 1'b0;
        saw_done = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done_s) saw_done++;
        end
        chk("no done after reset", saw_done, 0);
        chk("idle after reset", {busy_s, hi_s, lo_s}, 65'h0);
        do_op("DIVU 100/7 fresh", 2'b11, 32'd100, 32'd7, 32'd0, 32'd0,
              32'd2, 32'd14, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
